// File: rtl/fifo_read_packer_if.sv
// fifo_read_packer_if: bundles the FIFO read port, the flush request and the
// packed-word valid/ready output of the read-side packer.
interface fifo_read_packer_if #(
  parameter int FIFO_WIDTH = 3,
  parameter int PACK       = 4,
  parameter int CNTW       = 16
);
  localparam int KW = $clog2(PACK + 1);

  logic                         empty;
  logic [FIFO_WIDTH-1:0]        dout_b;
  logic                         ren_b;
  logic                         flush;
  logic [FIFO_WIDTH*PACK-1:0]   m_data;
  logic [KW-1:0]                m_keep;
  logic                         m_valid;
  logic                         m_ready;
  logic [CNTW-1:0]              pkt_cnt;

  // packer side: reads the FIFO, drives the packed word
  modport master (
    input  empty, dout_b, flush, m_ready,
    output ren_b, m_data, m_keep, m_valid, pkt_cnt
  );

  // environment side: FIFO plus downstream consumer
  modport slave (
    output empty, dout_b, flush, m_ready,
    input  ren_b, m_data, m_keep, m_valid, pkt_cnt
  );
endinterface

// File: rtl/fifo_read_packer.sv
// fifo_read_packer: pops narrow words from the read side of the dual-clock
// FIFO and packs PACK of them (first popped word in the low lane) into one
// wide word offered on a valid/ready bus. flush emits a partially filled word.
module fifo_read_packer #(
  parameter int FIFO_WIDTH = 3,
  parameter int PACK       = 4,
  parameter int CNTW       = 16
) (
  input  logic                clk_b,
  input  logic                rst,
  fifo_read_packer_if.master  bus
);
  localparam int KW = $clog2(PACK + 1);
  localparam int DW = FIFO_WIDTH * PACK;
  localparam logic [KW:0]   PACK_WIDE = (KW + 1)'(PACK);
  localparam logic [KW-1:0] PACK_KEEP = KW'(PACK);
  localparam logic [KW-1:0] LAST_LANE = KW'(PACK - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t          state_r, state_n;
  logic [KW-1:0]   cnt_r, cnt_n;
  logic            rd_pend_r;
  logic [DW-1:0]   data_r, data_n;
  logic [KW-1:0]   keep_r, keep_n;
  logic            valid_r, valid_n;
  logic [CNTW-1:0] pkt_r, pkt_n;
  logic            ren_s;
  logic [KW:0]     inflight_s;

  // lanes already filled plus the word still on its way from the FIFO
  assign inflight_s = {1'b0, cnt_r} + {{KW{1'b0}}, rd_pend_r};

  // read request: only while filling, never on an empty FIFO, never past PACK words
  always_comb begin
    ren_s = 1'b0;
    if (!rst && (state_r == FILL) && !bus.empty && (inflight_s < PACK_WIDE)) begin
      ren_s = 1'b1;
    end else begin
      ren_s = 1'b0;
    end
  end

  // next-state and datapath: lane capture, full/flush emission, output handshake
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    data_n  = data_r;
    keep_n  = keep_r;
    valid_n = valid_r;
    pkt_n   = pkt_r;
    case (state_r)
      FILL: begin
        if (rd_pend_r) begin
          for (int i = 0; i < PACK; i++) begin
            if (cnt_r == KW'(i)) begin
              data_n[i*FIFO_WIDTH +: FIFO_WIDTH] = bus.dout_b;
            end else begin
              data_n[i*FIFO_WIDTH +: FIFO_WIDTH] = data_r[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
          end
          cnt_n = cnt_r + KW'(1);
          if (cnt_r == LAST_LANE) begin
            state_n = OUT;
            valid_n = 1'b1;
            keep_n  = PACK_KEEP;
          end else begin
            state_n = FILL;
          end
        end else if (bus.flush && (cnt_r != {KW{1'b0}}) && !ren_s) begin
          // partial word: unfilled lanes are still zero from the last clear
          state_n = OUT;
          valid_n = 1'b1;
          keep_n  = cnt_r;
        end else begin
          state_n = FILL;
        end
      end
      OUT: begin
        if (valid_r && bus.m_ready) begin
          state_n = FILL;
          valid_n = 1'b0;
          cnt_n   = {KW{1'b0}};
          data_n  = {DW{1'b0}};
          keep_n  = {KW{1'b0}};
          pkt_n   = pkt_r + CNTW'(1);
        end else begin
          state_n = OUT;
        end
      end
      default: begin
        state_n = FILL;
      end
    endcase
  end

  // state and output registers; reset drops partial lanes and any in-flight read
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_r   <= FILL;
      cnt_r     <= {KW{1'b0}};
      rd_pend_r <= 1'b0;
      data_r    <= {DW{1'b0}};
      keep_r    <= {KW{1'b0}};
      valid_r   <= 1'b0;
      pkt_r     <= {CNTW{1'b0}};
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      rd_pend_r <= ren_s;
      data_r    <= data_n;
      keep_r    <= keep_n;
      valid_r   <= valid_n;
      pkt_r     <= pkt_n;
    end
  end

  assign bus.ren_b   = ren_s;
  assign bus.m_data  = data_r;
  assign bus.m_keep  = keep_r;
  assign bus.m_valid = valid_r;
  assign bus.pkt_cnt = pkt_r;
endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer: directed scenarios plus a randomized scoreboard run
// against a behavioural FIFO sharing clk_b and rst with the packer.
module tb_fifo_read_packer;
  localparam int FW = 3;
  localparam int PK = 4;
  localparam int CW = 16;

  logic clk_b = 1'b0;
  logic rst   = 1'b1;
  logic wr_en = 1'b0;
  logic [FW-1:0] wr_data = '0;
  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk_b = ~clk_b;

  fifo_read_packer_if #(.FIFO_WIDTH(FW), .PACK(PK), .CNTW(CW)) bus ();

  fifo_read_packer #(.FIFO_WIDTH(FW), .PACK(PK), .CNTW(CW)) dut (
    .clk_b (clk_b),
    .rst   (rst),
    .bus   (bus)
  );

  // behavioural FIFO: registered empty flag, dout_b valid the cycle after a pop
  logic [FW-1:0] fifo_q[$];
  always @(posedge clk_b) begin
    if (rst) begin
      fifo_q.delete();
      bus.empty  <= 1'b1;
      bus.dout_b <= '0;
    end else begin
      if (bus.ren_b && !bus.empty) bus.dout_b <= fifo_q.pop_front();
      if (wr_en) fifo_q.push_back(wr_data);
      bus.empty <= (fifo_q.size() == 0);
    end
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; bus.flush = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk_b);
    rst = 1'b0;
  endtask

  task automatic push(input logic [FW-1:0] v);
    wr_en = 1'b1; wr_data = v;
    @(negedge clk_b);
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && bus.m_valid !== 1'b1; i++) @(negedge clk_b);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; bus.flush = 1'b0; bus.m_ready = 1'b1;
    repeat (3) @(negedge clk_b);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.m_keep !== 3'd0) begin bad++; $display("FAIL rst_keep: got %0d want 0", bus.m_keep); end
    total++; if (bus.m_data !== 12'h000) begin bad++; $display("FAIL rst_data: got %h want 000", bus.m_data); end
    total++; if (bus.pkt_cnt !== 16'd0) begin bad++; $display("FAIL rst_pkt: got %0d want 0", bus.pkt_cnt); end
    total++; if (bus.ren_b !== 1'b0) begin bad++; $display("FAIL rst_ren: got %b want 0", bus.ren_b); end
    rst = 1'b0;
  endtask

  task automatic test_full_word();
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(FW'(i));
    wait_valid(20);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %b want 1 (timeout)", bus.m_valid); end
    total++; if (bus.m_data !== 12'h8D1) begin bad++; $display("FAIL full_data: got %h want 8d1", bus.m_data); end
    total++; if (bus.m_keep !== 3'd4) begin bad++; $display("FAIL full_keep: got %0d want 4", bus.m_keep); end
    @(negedge clk_b);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL full_drop: got %b want 0", bus.m_valid); end
    total++; if (bus.pkt_cnt !== 16'd1) begin bad++; $display("FAIL full_pkt: got %0d want 1", bus.pkt_cnt); end
  endtask

  task automatic test_backpressure();
    bit unstable;
    do_reset();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(FW'(i));
    wait_valid(20);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1 (timeout)", bus.m_valid); end
    total++; if (bus.m_data !== 12'h8D1) begin bad++; $display("FAIL bp_first: got %h want 8d1", bus.m_data); end
    unstable = 1'b0;
    repeat (6) begin
      @(negedge clk_b);
      if (bus.m_data !== 12'h8D1 || bus.ren_b !== 1'b0 || bus.m_valid !== 1'b1) unstable = 1'b1;
    end
    total++; if (unstable !== 1'b0) begin bad++; $display("FAIL bp_hold: got %b want 0 (data/ren_b moved while stalled)", unstable); end
    bus.m_ready = 1'b1;
    @(negedge clk_b);
    wait_valid(20);
    total++; if (bus.m_data !== 12'h1F5) begin bad++; $display("FAIL bp_second: got %h want 1f5", bus.m_data); end
    total++; if (bus.m_keep !== 3'd4) begin bad++; $display("FAIL bp_keep: got %0d want 4", bus.m_keep); end
    @(negedge clk_b);
    total++; if (bus.pkt_cnt !== 16'd2) begin bad++; $display("FAIL bp_pkt: got %0d want 2", bus.pkt_cnt); end
  endtask

  task automatic test_flush();
    bit seen;
    do_reset();
    bus.m_ready = 1'b1;
    push(3'd5);
    push(3'd6);
    repeat (6) @(negedge clk_b);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL fl_early: got %b want 0", bus.m_valid); end
    bus.flush = 1'b1;
    @(negedge clk_b);
    bus.flush = 1'b0;
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL fl_valid: got %b want 1", bus.m_valid); end
    total++; if (bus.m_data !== 12'h035) begin bad++; $display("FAIL fl_data: got %h want 035", bus.m_data); end
    total++; if (bus.m_keep !== 3'd2) begin bad++; $display("FAIL fl_keep: got %0d want 2", bus.m_keep); end
    @(negedge clk_b);
    total++; if (bus.pkt_cnt !== 16'd1) begin bad++; $display("FAIL fl_pkt: got %0d want 1", bus.pkt_cnt); end
    bus.flush = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_b);
      if (bus.m_valid !== 1'b0) seen = 1'b1;
    end
    bus.flush = 1'b0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL fl_empty: got %b want 0 (flush with no lanes emitted)", seen); end
    total++; if (bus.pkt_cnt !== 16'd1) begin bad++; $display("FAIL fl_empty_pkt: got %0d want 1", bus.pkt_cnt); end
  endtask

  task automatic test_empty_idle();
    bit busy;
    bit seen;
    logic [FW-1:0] words [4];
    words[0] = 3'd2; words[1] = 3'd4; words[2] = 3'd6; words[3] = 3'd1;
    do_reset();
    bus.m_ready = 1'b1;
    busy = 1'b0;
    repeat (20) begin
      @(negedge clk_b);
      if (bus.ren_b !== 1'b0 || bus.m_valid !== 1'b0) busy = 1'b1;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_quiet: got %b want 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(words[i]);
      if (!seen && bus.empty === 1'b0) begin
        seen = 1'b1;
        total++; if (bus.ren_b !== 1'b1) begin bad++; $display("FAIL idle_ren_rise: got %b want 1", bus.ren_b); end
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL idle_empty_drop: got %b want 1", seen); end
    wait_valid(20);
    total++; if (bus.m_data !== 12'h3A2) begin bad++; $display("FAIL idle_data: got %h want 3a2", bus.m_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(FW'(i));
    wait_valid(20);
    @(negedge clk_b);
    total++; if (bus.pkt_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre_pkt: got %0d want 1", bus.pkt_cnt); end
    push(3'd3);
    push(3'd3);
    repeat (4) @(negedge clk_b);
    total++; if (bus.m_data !== 12'h01B) begin bad++; $display("FAIL mid_partial: got %h want 01b", bus.m_data); end
    rst = 1'b1;
    @(negedge clk_b);
    rst = 1'b0;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.pkt_cnt !== 16'd0) begin bad++; $display("FAIL mid_pkt: got %0d want 0", bus.pkt_cnt); end
    total++; if (bus.m_data !== 12'h000) begin bad++; $display("FAIL mid_data: got %h want 000", bus.m_data); end
    push(3'd7); push(3'd0); push(3'd1); push(3'd2);
    wait_valid(20);
    total++; if (bus.m_data !== 12'h447) begin bad++; $display("FAIL mid_after: got %h want 447", bus.m_data); end
    total++; if (bus.m_keep !== 3'd4) begin bad++; $display("FAIL mid_keep: got %0d want 4", bus.m_keep); end
  endtask

  task automatic test_random();
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] lane;
    logic [FW-1:0] want;
    logic [11:0]   d;
    int            keep;
    int            words_out;
    do_reset();
    words_out = 0;
    for (int cyc = 0; cyc < 2100; cyc++) begin
      if (cyc < 2000) begin
        bus.m_ready = ($urandom_range(0, 3) != 0);
        bus.flush   = ($urandom_range(0, 7) == 0);
        wr_en       = 1'($urandom_range(0, 1));
        wr_data     = FW'($urandom);
      end else begin
        bus.m_ready = 1'b1;
        bus.flush   = 1'b1;
        wr_en       = 1'b0;
      end
      if (wr_en) exp_q.push_back(wr_data);
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        d = bus.m_data;
        keep = int'(bus.m_keep);
        words_out++;
        total++; if (keep < 1 || keep > PK) begin bad++; $display("FAIL rnd_keep: got %0d want 1..4", keep); end
        for (int i = 0; i < PK; i++) begin
          lane = d[i*FW +: FW];
          if (i < keep) begin
            if (exp_q.size() == 0) begin
              total++; bad++; $display("FAIL rnd_extra: got lane %0d want nothing pending", lane);
            end else begin
              want = exp_q.pop_front();
              total++; if (lane !== want) begin bad++; $display("FAIL rnd_lane%0d: got %0d want %0d", i, lane, want); end
            end
          end else begin
            total++; if (lane !== 3'd0) begin bad++; $display("FAIL rnd_pad%0d: got %0d want 0", i, lane); end
          end
        end
      end
      @(negedge clk_b);
    end
    bus.flush = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_left: got %0d words undelivered want 0", exp_q.size()); end
    total++; if (words_out < 100) begin bad++; $display("FAIL rnd_count: got %0d output words want >=100", words_out); end
  endtask

  // test sequence
  initial begin
    bus.flush = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_full_word();
    test_backpressure();
    test_flush();
    test_empty_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
